// File: rtl/raster_pkg.sv
// Shared types and default widths for the raster scan counter.
package raster_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_STOP = 1'b1
  } cnt_mode_e;

  localparam int unsigned DEF_COL_BITS = 9;
  localparam int unsigned DEF_ROW_BITS = 9;

endpackage

// File: rtl/counter_cell.sv
// One bidirectional rollover counter stage with a runtime upper bound.
// term is combinational so the next stage can advance on the same edge.
module counter_cell #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned START = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dir_down,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] value,
  output logic             term
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  logic [WIDTH-1:0] reload_down;
  logic [WIDTH-1:0] next_value;

  // A bound at or below the floor pins the down-count reload to the floor.
  always_comb begin
    reload_down = (max > START_V) ? max : START_V;
    term        = dir_down ? (value <= START_V) : (value >= max);
    next_value  = value;
    if (clr) begin
      next_value = dir_down ? max : START_V;
    end else if (en) begin
      if (term) begin
        next_value = dir_down ? reload_down : START_V;
      end else if (dir_down) begin
        next_value = (value > max) ? reload_down : value - WIDTH'(1);
      end else begin
        next_value = value + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= START_V;
    end else begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/raster_scan_counter.sv
// Column/row raster walker with registered line/frame pulses and a sticky done flag.
module raster_scan_counter
  import raster_pkg::*;
#(
  parameter int unsigned COL_BITS  = DEF_COL_BITS,
  parameter int unsigned ROW_BITS  = DEF_ROW_BITS,
  parameter int unsigned COL_START = 0,
  parameter int unsigned ROW_START = 0,
  parameter cnt_mode_e   MODE      = MODE_WRAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                count_enable,
  input  logic                sync_reset,
  input  logic                dir_down,
  input  logic [COL_BITS-1:0] col_max,
  input  logic [ROW_BITS-1:0] row_max,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                line_end,
  output logic                frame_end,
  output logic                done
);

  logic frozen;
  logic col_en;
  logic row_en;
  logic col_term;
  logic row_term;

  // Stop mode parks the scan once a frame completes; sync_reset wins over everything.
  assign frozen = (MODE == MODE_STOP) && done;
  assign col_en = count_enable && !frozen && !sync_reset;
  assign row_en = col_en && col_term;

  counter_cell #(
    .WIDTH (COL_BITS),
    .START (COL_START)
  ) u_col (
    .clk      (clk),
    .rst      (rst),
    .en       (col_en),
    .clr      (sync_reset),
    .dir_down (dir_down),
    .max      (col_max),
    .value    (col),
    .term     (col_term)
  );

  counter_cell #(
    .WIDTH (ROW_BITS),
    .START (ROW_START)
  ) u_row (
    .clk      (clk),
    .rst      (rst),
    .en       (row_en),
    .clr      (sync_reset),
    .dir_down (dir_down),
    .max      (row_max),
    .value    (row),
    .term     (row_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else if (sync_reset) begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      line_end  <= row_en;
      frame_end <= row_en && row_term;
      if (row_en && row_term) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raster_scan_counter.sv
// Scoreboard bench: wrap and stop instances driven together against a pixel-walk model.
module tb_raster_scan_counter;
  import raster_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       count_enable;
  logic       sync_reset;
  logic       dir_down;
  logic [3:0] col_max;
  logic [3:0] row_max;

  logic [3:0] col_w, row_w, col_s, row_s;
  logic       le_w, fe_w, done_w, le_s, fe_s, done_s;

  always #5 clk = ~clk;

  raster_scan_counter #(
    .COL_BITS(4), .ROW_BITS(4), .COL_START(0), .ROW_START(0), .MODE(MODE_WRAP)
  ) dut_wrap (
    .clk(clk), .rst(rst), .count_enable(count_enable), .sync_reset(sync_reset),
    .dir_down(dir_down), .col_max(col_max), .row_max(row_max),
    .col(col_w), .row(row_w), .line_end(le_w), .frame_end(fe_w), .done(done_w)
  );

  raster_scan_counter #(
    .COL_BITS(4), .ROW_BITS(4), .COL_START(0), .ROW_START(0), .MODE(MODE_STOP)
  ) dut_stop (
    .clk(clk), .rst(rst), .count_enable(count_enable), .sync_reset(sync_reset),
    .dir_down(dir_down), .col_max(col_max), .row_max(row_max),
    .col(col_s), .row(row_s), .line_end(le_s), .frame_end(fe_s), .done(done_s)
  );

  typedef struct {
    int col;
    int row;
    bit le;
    bit fe;
    bit done;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t stage_w, stage_s;
  bit   stage_valid = 1'b0;

  int m_col[2];
  int m_row[2];
  bit m_done[2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic exp_t mk(int c, int r, bit le, bit fe, bit d);
    exp_t e;
    e.col = c; e.row = r; e.le = le; e.fe = fe; e.done = d;
    return e;
  endfunction

  // Pixel-walk reference: one call per clock edge that samples these inputs.
  function automatic exp_t step(int idx, bit stop, bit sr, bit en, bit dn, int cmax, int rmax);
    bit le = 1'b0;
    bit fe = 1'b0;
    if (sr) begin
      m_col[idx]  = dn ? cmax : 0;
      m_row[idx]  = dn ? rmax : 0;
      m_done[idx] = 1'b0;
    end else if (stop && m_done[idx]) begin
      le = 1'b0;
    end else if (en) begin
      if (!dn) begin
        if (m_col[idx] >= cmax) begin
          m_col[idx] = 0;
          le = 1'b1;
          if (m_row[idx] >= rmax) begin
            m_row[idx] = 0;
            fe = 1'b1;
          end else begin
            m_row[idx] = m_row[idx] + 1;
          end
        end else begin
          m_col[idx] = m_col[idx] + 1;
        end
      end else begin
        if (m_col[idx] <= 0) begin
          m_col[idx] = cmax;
          le = 1'b1;
          if (m_row[idx] <= 0) begin
            m_row[idx] = rmax;
            fe = 1'b1;
          end else if (m_row[idx] > rmax) begin
            m_row[idx] = rmax;
          end else begin
            m_row[idx] = m_row[idx] - 1;
          end
        end else if (m_col[idx] > cmax) begin
          m_col[idx] = cmax;
        end else begin
          m_col[idx] = m_col[idx] - 1;
        end
      end
      if (fe) m_done[idx] = 1'b1;
    end
    return mk(m_col[idx], m_row[idx], le, fe, m_done[idx]);
  endfunction

  task automatic check(string name, exp_t e, logic [3:0] c, logic [3:0] r, logic le, logic fe, logic d);
    n_checks++;
    if (e.col != int'(c) || e.row != int'(r) || e.le != le || e.fe != fe || e.done != d) begin
      n_fail++;
      $display("FAIL %s @%0t: got col=%0d row=%0d le=%0b fe=%0b done=%0b, want col=%0d row=%0d le=%0b fe=%0b done=%0b",
               name, $time, c, r, le, fe, d, e.col, e.row, e.le, e.fe, e.done);
    end
  endtask

  // Every edge that sampled staged stimulus yields one expected response.
  always @(posedge clk) begin
    if (stage_valid) begin
      q_w.push_back(stage_w);
      q_s.push_back(stage_s);
    end
  end

  always @(negedge clk) begin
    if (q_w.size() > 0) check("wrap", q_w.pop_front(), col_w, row_w, le_w, fe_w, done_w);
    if (q_s.size() > 0) check("stop", q_s.pop_front(), col_s, row_s, le_s, fe_s, done_s);
  end

  task automatic apply(bit sr, bit en, bit dn, int cmax, int rmax);
    @(negedge clk);
    sync_reset   = sr;
    count_enable = en;
    dir_down     = dn;
    col_max      = 4'(cmax);
    row_max      = 4'(rmax);
    stage_w      = step(0, 1'b0, sr, en, dn, cmax, rmax);
    stage_s      = step(1, 1'b1, sr, en, dn, cmax, rmax);
    stage_valid  = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    stage_valid  = 1'b0;
    sync_reset   = 1'b0;
    count_enable = 1'b0;
    for (int i = 0; i < 10 && (q_w.size() > 0 || q_s.size() > 0); i++) @(negedge clk);
    n_checks++;
    if (q_w.size() > 0 || q_s.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d responses never checked, want 0", q_w.size(), q_s.size());
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_col[i] = 0; m_row[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    int cm, rm;
    bit dn;
    rst = 1'b1; count_enable = 1'b0; sync_reset = 1'b0; dir_down = 1'b0;
    col_max = 4'd3; row_max = 4'd2;
    reset_model();
    #1;
    check("reset_wrap", mk(0, 0, 0, 0, 0), col_w, row_w, le_w, fe_w, done_w);
    check("reset_stop", mk(0, 0, 0, 0, 0), col_s, row_s, le_s, fe_s, done_s);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Async reset mid-frame at (2,1), with no clock edge before the check.
    repeat (6) apply(0, 1, 0, 3, 2);
    drain();
    #2 rst = 1'b1;
    #1;
    reset_model();
    check("async_rst_wrap", mk(0, 0, 0, 0, 0), col_w, row_w, le_w, fe_w, done_w);
    check("async_rst_stop", mk(0, 0, 0, 0, 0), col_s, row_s, le_s, fe_s, done_s);
    @(negedge clk);
    rst = 1'b0;

    // Up scan: wrap keeps going, stop freezes after the frame end.
    repeat (20) apply(0, 1, 0, 3, 2);
    apply(1, 0, 0, 3, 2);
    repeat (3) apply(0, 1, 0, 3, 2);

    // Down scan from the programmed maxima.
    apply(1, 0, 1, 3, 2);
    repeat (13) apply(0, 1, 1, 3, 2);

    // Enable gaps: pulses must not stretch.
    apply(1, 0, 0, 3, 2);
    for (int i = 0; i < 16; i++) apply(0, (i % 2 == 0) || (i % 5 == 0), 0, 3, 2);

    // sync_reset beats count_enable at the final pixel.
    apply(1, 0, 0, 3, 2);
    repeat (11) apply(0, 1, 0, 3, 2);
    apply(1, 1, 0, 3, 2);
    apply(0, 1, 0, 3, 2);

    // Bound shrink below the current column, then a degenerate bound.
    apply(1, 0, 0, 9, 3);
    repeat (7) apply(0, 1, 0, 9, 3);
    apply(0, 1, 0, 4, 3);
    repeat (4) apply(0, 1, 0, 0, 3);

    // Randomized scans with bound changes, direction flips and restarts.
    cm = 3; rm = 2; dn = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) cm = $urandom_range(0, 7);
      if ($urandom_range(0, 24) == 0) rm = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) dn = ~dn;
      if ($urandom_range(0, 59) == 0) begin
        cm = $urandom_range(0, 15);
        rm = $urandom_range(0, 15);
      end
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, dn, cm, rm);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_scan_counter.md
Name: raster_scan_counter

Overview:
- Parametrised two-level (column/row) successor of the single rollover counter, used to walk pixel windows across a frame for the Canny pipeline stages.
- Column counter cascades into row counter.
- Outputs a registered line_end/frame_end pulse pair plus a sticky done flag.
- Supports up/down scanning, runtime-programmable bounds, and wrap or stop-at-frame-end modes.

Parameters:
- COL_BITS, 9, width of column counter and col_max.
- ROW_BITS, 9, width of row counter and row_max.
- COL_START, 0, column reset/reload floor value.
- ROW_START, 0, row reset/reload floor value.
- MODE, MODE_WRAP, MODE_WRAP restarts the frame after the last pixel; MODE_STOP freezes until sync_reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- count_enable  in  1  advance one pixel this cycle.
- sync_reset  in  1  synchronous restart; priority over count_enable.
- dir_down  in  1  0 = count up (START to max), 1 = count down (max to START).
- col_max  in  COL_BITS  last column value (inclusive).
- row_max  in  ROW_BITS  last row value (inclusive).
- col  out  COL_BITS  current column.
- row  out  ROW_BITS  current row.
- line_end  out  1  one-cycle pulse, registered.
- frame_end  out  1  one-cycle pulse, registered.
- done  out  1  sticky frame-complete flag.

Behaviour:
- rst=1 (async): col=COL_START, row=ROW_START, line_end=0, frame_end=0, done=0.
- Per edge, priority order: sync_reset > frozen > count_enable > hold.
- sync_reset=1:
  - up mode: col=COL_START, row=ROW_START.
  - down mode: col=col_max, row=row_max.
  - line_end, frame_end and done all clear.
- Frozen: MODE_STOP and done=1. col/row hold, pulses 0, count_enable ignored.
- count_enable=1, up mode:
  - col terminal when col >= col_max, including a max lowered mid-run.
  - Terminal: col = COL_START and line_end=1 next cycle.
  - Row advances in the same edge. Row terminal when row >= row_max. Terminal: row = ROW_START and frame_end=1; otherwise row+1.
  - Non-terminal: col+1.
- count_enable=1, down mode:
  - col terminal when col <= COL_START. Terminal: col = col_max, line_end=1, and row steps down analogously (terminal at ROW_START, reload row_max, frame_end=1).
  - If col > col_max (max lowered), next col = col_max with no pulse. Row clamps likewise.
- count_enable=0: col/row hold; line_end=0, frame_end=0. Pulses never stretch.
- frame_end=1 implies line_end=1 on the same cycle.
- done is set on the edge that asserts frame_end and stays set until sync_reset or rst.
  - MODE_WRAP: counting continues.
  - MODE_STOP: in up mode col/row still reload to START on that edge, then freeze.
- Degenerate bounds: col_max <= COL_START means every enabled cycle is a line end and col stays COL_START. Rows behave the same way.
- dir_down change: applies on the next enabled edge, with no reload.
- Latency: col/row/pulses update one clock after the enabling edge inputs. No combinational input-to-output path.
- Arithmetic: unsigned, no carry out of COL_BITS/ROW_BITS. Comparisons are full-width unsigned.
- rst mid-frame: immediate async return to reset values. The first enabled cycle after release advances from START.

Decomposition:
- raster_pkg: typedef enum logic {MODE_WRAP, MODE_STOP} cnt_mode_e, plus localparam defaults for COL_BITS/ROW_BITS.
- Sub-module counter_cell (params WIDTH, START):
  - Inputs: clk, rst, en, clr, dir_down, max.
  - Outputs: value, term (combinational terminal indication).
  - Instantiated twice. Column en = top enable. Row en = top enable AND column term.
- Pulse, done and freeze logic stay in raster_scan_counter.

Test Plan:
- Async reset: COL_BITS=ROW_BITS=4, START=0. Assert rst mid-count at col=2,row=1 -> col=0,row=0, flags 0 without a clock edge.
- Up wrap: col_max=3, row_max=2, enable held 12 cycles.
  - Sequence (0,0)..(3,2) then (0,0).
  - line_end pulses on cycles 4, 8, 12.
  - frame_end and done assert on cycle 12; done stays 1.
- MODE_STOP: same bounds, enable held 20 cycles.
  - Reaches (0,0) with frame_end after 12 cycles, then holds.
  - done=1, no further pulses, until sync_reset clears done.
- Down scan: dir_down=1, sync_reset first -> (3,2). Enable 12 cycles -> (2,2),(1,2),(0,2),(3,1)...; frame_end after (0,0).
- Gaps/priority:
  - Enable toggling 1,0,1 -> pulses last exactly one cycle; values hold on 0.
  - sync_reset and count_enable asserted together at (3,2) -> (0,0), no frame_end.
- Bound shrink: at col=7, set col_max=4 -> next enabled edge col=0 with line_end=1. Set col_max=0 -> line_end every enabled cycle.
